// File: rtl/decode_stage_pkg.sv
// Shared RV32I encodings, ALU operation codes, skid-buffer states and the
// decoded-field bundle passed from the combinational decoder to the stage.
package decode_stage_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_SLL     = 3'b001;
    localparam logic [2:0] FUNCT3_SLT     = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
    localparam logic [2:0] FUNCT3_XOR     = 3'b100;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
    localparam logic [2:0] FUNCT3_OR      = 3'b110;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // Code 0 is reserved so an illegal instruction never looks like a real op.
    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SLL  = 4'd3,
        ALU_SLT  = 4'd4,
        ALU_SLTU = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_OR   = 4'd9,
        ALU_AND  = 4'd10
    } alu_op_e;

    localparam alu_op_e ALU_ADDI = ALU_ADD;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       we;
        logic       writeback;
        logic       is_jump;
        logic       is_branch;
        logic       is_load;
        logic       is_store;
        logic       illegal;
    } dec_fields_t;

    localparam int FIELDS_W = $bits(dec_fields_t);

    // alt selects SUB/SRA; callers decide when the alternate encoding applies.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            FUNCT3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            FUNCT3_SLL:     op = ALU_SLL;
            FUNCT3_SLT:     op = ALU_SLT;
            FUNCT3_SLTU:    op = ALU_SLTU;
            FUNCT3_XOR:     op = ALU_XOR;
            FUNCT3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            FUNCT3_OR:      op = ALU_OR;
            default:        op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_rv32i_comb.sv
// Purely combinational RV32I decoder: instruction word to register indices,
// sign-extended immediate, ALU op and class/control flags.
module decode_rv32i_comb
    import decode_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic [31:0]          i_inst,
    output logic [FIELDS_W-1:0]  o_fields,
    output logic [XLEN-1:0]      o_imm,
    output logic [ALU_OP_W-1:0]  o_alu_op
);

    dec_fields_t        w_f;
    logic signed [31:0] w_imm32;
    alu_op_e            w_alu;
    logic               w_legal;
    logic               w_writes;

    always_comb begin
        w_f      = '0;
        w_imm32  = '0;
        w_alu    = ALU_NOP;
        w_legal  = 1'b1;
        w_writes = 1'b0;

        w_f.opcode = i_inst[6:0];
        w_f.funct3 = i_inst[14:12];
        w_f.funct7 = i_inst[31:25];
        w_f.rs1    = i_inst[19:15];
        w_f.rs2    = i_inst[24:20];
        w_f.rd     = i_inst[11:7];

        case (i_inst[6:0])
            OPC_OP: begin
                if (i_inst[31:25] == FUNCT7_BASE || i_inst[31:25] == FUNCT7_ALT) begin
                    w_alu    = alu_from_funct3(i_inst[14:12], i_inst[30]);
                    w_writes = 1'b1;
                end else begin
                    w_legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                // inst[30] is immediate data except for SRAI, so ADDI never becomes SUB.
                w_imm32  = {{20{i_inst[31]}}, i_inst[31:20]};
                w_alu    = alu_from_funct3(i_inst[14:12],
                                           (i_inst[14:12] == FUNCT3_SRL_SRA) && i_inst[30]);
                w_writes = 1'b1;
            end
            OPC_LOAD: begin
                w_imm32     = {{20{i_inst[31]}}, i_inst[31:20]};
                w_alu       = ALU_ADD;
                w_writes    = 1'b1;
                w_f.is_load = 1'b1;
                w_f.writeback = 1'b1;
            end
            OPC_STORE: begin
                w_imm32      = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
                w_alu        = ALU_ADD;
                w_f.is_store = 1'b1;
            end
            OPC_BRANCH: begin
                w_imm32       = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                                 i_inst[11:8], 1'b0};
                w_alu         = ALU_SUB;
                w_f.is_branch = 1'b1;
            end
            OPC_JAL: begin
                w_imm32       = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                                 i_inst[30:21], 1'b0};
                w_alu         = ALU_ADD;
                w_writes      = 1'b1;
                w_f.is_jump   = 1'b1;
                w_f.writeback = 1'b1;
            end
            OPC_JALR: begin
                w_imm32       = {{20{i_inst[31]}}, i_inst[31:20]};
                w_alu         = ALU_ADD;
                w_writes      = 1'b1;
                w_f.is_jump   = 1'b1;
                w_f.writeback = 1'b1;
            end
            OPC_LUI: begin
                // LUI executes as x0 + imm on the shared adder.
                w_imm32  = {i_inst[31:12], 12'b0};
                w_alu    = ALU_ADD;
                w_writes = 1'b1;
                w_f.rs1  = 5'd0;
            end
            OPC_AUIPC: begin
                w_imm32  = {i_inst[31:12], 12'b0};
                w_alu    = ALU_ADD;
                w_writes = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase

        if (!w_legal) begin
            w_alu       = ALU_NOP;
            w_imm32     = '0;
            w_writes    = 1'b0;
            w_f.illegal = 1'b1;
        end
        w_f.we = w_writes && (i_inst[11:7] != 5'd0);
    end

    assign o_fields = w_f;
    assign o_imm    = XLEN'(w_imm32);
    assign o_alu_op = ALU_OP_W'(w_alu);

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready handshake and an optional
// 2-entry skid buffer so in_ready can be a flop without losing throughput.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4,
    parameter int HAS_SKID = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [31:0]         i_in_inst,
    input  logic [XLEN-1:0]     i_in_pc,
    input  logic                i_flush,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [XLEN-1:0]     o_out_pc,
    output logic [6:0]          o_opcode,
    output logic [2:0]          o_funct3,
    output logic [6:0]          o_funct7,
    output logic [4:0]          o_rs1,
    output logic [4:0]          o_rs2,
    output logic [4:0]          o_rd,
    output logic [XLEN-1:0]     o_imm,
    output logic [ALU_OP_W-1:0] o_alu_op,
    output logic                o_we,
    output logic                o_writeback,
    output logic                o_is_jump,
    output logic                o_is_branch,
    output logic                o_is_load,
    output logic                o_is_store,
    output logic                o_illegal
);

    skid_state_e           r_state;
    skid_state_e           w_state_nxt;
    logic                  r_in_ready;
    logic                  w_accept;
    logic                  w_take;
    logic                  w_load_main;
    logic                  w_load_skid;
    logic                  w_skid_to_main;

    logic [FIELDS_W-1:0]   w_dec_vec;
    dec_fields_t           w_dec_f;
    logic [XLEN-1:0]       w_dec_imm;
    logic [ALU_OP_W-1:0]   w_dec_alu;

    dec_fields_t           r_main_f;
    logic [XLEN-1:0]       r_main_pc;
    logic [XLEN-1:0]       r_main_imm;
    logic [ALU_OP_W-1:0]   r_main_alu;
    dec_fields_t           r_skid_f;
    logic [XLEN-1:0]       r_skid_pc;
    logic [XLEN-1:0]       r_skid_imm;
    logic [ALU_OP_W-1:0]   r_skid_alu;

    decode_rv32i_comb #(
        .XLEN     (XLEN),
        .ALU_OP_W (ALU_OP_W)
    ) u_dec (
        .i_inst   (i_in_inst),
        .o_fields (w_dec_vec),
        .o_imm    (w_dec_imm),
        .o_alu_op (w_dec_alu)
    );

    assign w_dec_f = dec_fields_t'(w_dec_vec);

    // Without the skid entry, readiness must follow out_ready combinationally.
    assign o_out_valid = (r_state != ST_EMPTY);
    assign o_in_ready  = r_in_ready && ((HAS_SKID != 0) || i_out_ready || !o_out_valid);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_take      = o_out_valid && i_out_ready && !i_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
            ST_ONE: begin
                if (w_accept && !w_take)      w_state_nxt = ST_TWO;
                else if (!w_accept && w_take) w_state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (w_take) w_state_nxt = ST_ONE;
            default:  w_state_nxt = ST_EMPTY;
        endcase
        if (i_flush) w_state_nxt = ST_EMPTY;
    end

    always_comb begin
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        unique case (r_state)
            ST_EMPTY: w_load_main = w_accept;
            ST_ONE: begin
                w_load_main = w_accept && w_take;
                w_load_skid = w_accept && !w_take;
            end
            ST_TWO:   w_skid_to_main = w_take;
            default: ;
        endcase
    end

    // Payload: main register drives the outputs, skid holds the overflow entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_main_f   <= '0;
            r_main_pc  <= '0;
            r_main_imm <= '0;
            r_main_alu <= '0;
            r_skid_f   <= '0;
            r_skid_pc  <= '0;
            r_skid_imm <= '0;
            r_skid_alu <= '0;
        end else begin
            if (w_load_main) begin
                r_main_f   <= w_dec_f;
                r_main_pc  <= i_in_pc;
                r_main_imm <= w_dec_imm;
                r_main_alu <= w_dec_alu;
            end else if (w_skid_to_main) begin
                r_main_f   <= r_skid_f;
                r_main_pc  <= r_skid_pc;
                r_main_imm <= r_skid_imm;
                r_main_alu <= r_skid_alu;
            end
            if (w_load_skid) begin
                r_skid_f   <= w_dec_f;
                r_skid_pc  <= i_in_pc;
                r_skid_imm <= w_dec_imm;
                r_skid_alu <= w_dec_alu;
            end
        end
    end

    assign o_out_pc    = r_main_pc;
    assign o_opcode    = r_main_f.opcode;
    assign o_funct3    = r_main_f.funct3;
    assign o_funct7    = r_main_f.funct7;
    assign o_rs1       = r_main_f.rs1;
    assign o_rs2       = r_main_f.rs2;
    assign o_rd        = r_main_f.rd;
    assign o_imm       = r_main_imm;
    assign o_alu_op    = r_main_alu;
    assign o_we        = r_main_f.we;
    assign o_writeback = r_main_f.writeback;
    assign o_is_jump   = r_main_f.is_jump;
    assign o_is_branch = r_main_f.is_branch;
    assign o_is_load   = r_main_f.is_load;
    assign o_is_store  = r_main_f.is_store;
    assign o_illegal   = r_main_f.illegal;

endmodule
